sdp_ram_be: RTL

Parametrised simple dual-port RAM: one write port with byte enables, one read port with a valid strobe and selectable read latency. After every reset a built-in clear sequencer zeroes all contents. It is the general-purpose on-chip buffer for datapath blocks, replacing fixed 16x16 single-clock RAMs. Same-address read/write collisions resolve write-first, and out-of-range accesses are flagged.

---
 rtl/sdp_ram_pkg.sv | 19 +
 rtl/sdp_ram_clear_seq.sv | 45 ++++
 rtl/sdp_ram_be.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/sdp_ram_pkg.sv
// Shared types and helpers for the byte-enable simple dual-port RAM.
// Optional parity storage is enabled by defining SDP_RAM_PARITY_EN.
package sdp_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } sdp_ram_state_e;

  function automatic int be_w(input int data_w);
    return data_w / 8;
  endfunction

  // Even parity: the stored bit makes the byte plus parity have even ones
  function automatic logic par8(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/sdp_ram_clear_seq.sv
// Post-reset clear sequencer: walks every address once writing zero,
// then raises init_done and stays READY until the next reset.
module sdp_ram_clear_seq
  import sdp_ram_pkg::*;
#(
  parameter int AW    = 4,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          clear_we,
  output logic [AW-1:0] clear_addr,
  output logic          init_done
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  sdp_ram_state_e  state;
  logic [AW-1:0]   cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= CLEAR;
      cnt       <= '0;
      init_done <= 1'b0;
    end else begin
      unique case (state)
        CLEAR: begin
          if (cnt == LAST) begin
            state     <= READY;
            init_done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        READY:   state <= READY;
        default: state <= CLEAR;
      endcase
    end
  end

  assign clear_we   = (state == CLEAR);
  assign clear_addr = cnt;

endmodule

// File: rtl/sdp_ram_be.sv
// Simple dual-port RAM with byte enables, write-first collisions and
// range checking. Define SDP_RAM_PARITY_EN for per-byte parity.
module sdp_ram_be
  import sdp_ram_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 6,
  parameter int DEPTH   = 16,
  parameter int OUT_REG = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [be_w(DATA_W)-1:0]  wr_be,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     init_done,
  output logic                     addr_err
`ifdef SDP_RAM_PARITY_EN
  ,
  output logic                     parity_err
`endif
);

  localparam int BE = be_w(DATA_W);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LIM = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic          clear_we;
  logic [IW-1:0] ca;
  logic          clr;

  sdp_ram_clear_seq #(
    .AW    (IW),
    .DEPTH (DEPTH)
  ) u_clear (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_we   (clear_we),
    .clear_addr (ca),
    .init_done  (init_done)
  );

  logic          wr_in;
  logic          rd_in;
  logic          wr_ok;
  logic          rd_act;
  logic          rd_ok;
  logic          coll;
  logic [IW-1:0] wa;
  logic [IW-1:0] ra;

  assign clr    = clear_we && rst_n;
  assign wr_in  = {1'b0, wr_addr} < LIM;
  assign rd_in  = {1'b0, rd_addr} < LIM;
  assign wa     = wr_addr[IW-1:0];
  assign ra     = rd_addr[IW-1:0];
  assign wr_ok  = rst_n && init_done && wr_en && wr_in;
  assign rd_act = rst_n && init_done && rd_en;
  assign rd_ok  = rd_act && rd_in;
  assign coll   = wr_ok && rd_ok && (wr_addr == rd_addr);

  logic [DATA_W-1:0] wr_old;
  logic [DATA_W-1:0] wr_new;
  logic [DATA_W-1:0] rd_word;

  always_comb begin
    wr_old = mem[wa];
    wr_new = wr_old;
    for (int b = 0; b < BE; b++) begin
      if (wr_be[b]) wr_new[8*b +: 8] = wr_data[8*b +: 8];
    end
    rd_word = coll ? wr_new : mem[ra];
  end

`ifdef SDP_RAM_PARITY_EN
  logic [BE-1:0] par [DEPTH];
  logic [BE-1:0] par_new;
  logic [BE-1:0] rd_par;
  logic          rd_bad;

  always_comb begin
    par_new = par[wa];
    for (int b = 0; b < BE; b++) begin
      if (wr_be[b]) par_new[b] = par8(wr_data[8*b +: 8]);
    end
    rd_par = coll ? par_new : par[ra];
    rd_bad = 1'b0;
    for (int b = 0; b < BE; b++) begin
      if (par8(rd_word[8*b +: 8]) != rd_par[b]) rd_bad = 1'b1;
    end
    rd_bad = rd_bad && rd_ok;
  end

  always_ff @(posedge clk) begin
    if (clr) par[ca] <= '0;
    else if (wr_ok) par[wa] <= par_new;
  end
`endif

  always_ff @(posedge clk) begin
    if (clr) mem[ca] <= '0;
    else if (wr_ok) mem[wa] <= wr_new;
  end

  logic              v1;
  logic [DATA_W-1:0] d1;
`ifdef SDP_RAM_PARITY_EN
  logic              pe1;
`endif

  // Out-of-range reads still return a valid beat, carrying zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1       <= 1'b0;
      d1       <= '0;
      addr_err <= 1'b0;
`ifdef SDP_RAM_PARITY_EN
      pe1      <= 1'b0;
`endif
    end else begin
      v1       <= rd_act;
      if (rd_act) d1 <= rd_in ? rd_word : '0;
      addr_err <= init_done &&
                  ((wr_en && !wr_in) || (rd_en && !rd_in));
`ifdef SDP_RAM_PARITY_EN
      pe1      <= rd_bad;
`endif
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic              v2;
      logic [DATA_W-1:0] d2;
`ifdef SDP_RAM_PARITY_EN
      logic              pe2;
`endif
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          v2  <= 1'b0;
          d2  <= '0;
`ifdef SDP_RAM_PARITY_EN
          pe2 <= 1'b0;
`endif
        end else begin
          v2  <= v1;
          if (v1) d2 <= d1;
`ifdef SDP_RAM_PARITY_EN
          pe2 <= pe1 && v1;
`endif
        end
      end
      assign rd_valid   = v2;
      assign rd_data    = d2;
`ifdef SDP_RAM_PARITY_EN
      assign parity_err = pe2;
`endif
    end else begin : g_noreg
      assign rd_valid   = v1;
      assign rd_data    = d1;
`ifdef SDP_RAM_PARITY_EN
      assign parity_err = pe1;
`endif
    end
  endgenerate

endmodule
